mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 6, meaning width of alu_ctrl.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning maximum cycles mem_req may wait for mem_ready; range 1..255.
REQ-003 SHALL have parameter RETIRE_W, default 32, meaning width of the retired-instruction counter.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning the reset; asynchronous and active-low.
REQ-006 SHALL have ports opcode (input, 6, instruction[31:26]) and funct (input, 6, instruction[5:0]); both are sampled only in DECODE and EXEC.
REQ-007 SHALL have ports mem_ready (input, 1, memory completes the request this cycle), mem_req (output, 1) and mem_we (output, 1).
REQ-008 SHALL have datapath-control outputs, each 1 bit unless stated: pc_write, pc_write_cond, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b [1:0], pc_src [1:0], and alu_ctrl [ALU_CTRL_W-1:0].
REQ-009 SHALL have status outputs state [3:0], illegal_instr (1-cycle pulse), bus_error (1-cycle pulse) and retired [RETIRE_W-1:0].

Function
REQ-010 SHALL implement a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11.
REQ-011 FETCH SHALL drive mem_req=1, i_or_d=0 and alu_src_b=01, and hold the state until mem_ready=1; ir_write and pc_write SHALL be 1 only in the mem_ready=1 cycle, after which the state is DECODE.
REQ-012 DECODE SHALL drive alu_src_b=11 and branch on opcode: 0x00 to EXEC, 0x23 or 0x2b to MEM_ADR, 0x08 to ADDI_EX, 0x04 to BRANCH, 0x02 to JUMP; any other opcode SHALL pulse illegal_instr and go to FETCH.
REQ-013 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_ctrl=0x20, then go to MEM_RD if opcode=0x23, or to MEM_WR if opcode=0x2b.
REQ-014 MEM_RD SHALL drive mem_req=1 and i_or_d=1 and wait for mem_ready, then go to MEM_WB.
REQ-015 MEM_WB SHALL drive reg_write=1 and mem_to_reg=1 (reg_dst=0), then go to FETCH.
REQ-016 MEM_WR SHALL drive mem_req=1, mem_we=1 and i_or_d=1 and wait for mem_ready, then go to FETCH.
REQ-017 EXEC SHALL drive alu_src_a=1 and alu_src_b=00, and decode funct to alu_ctrl: 0x20→0x20, 0x22→0x22, 0x24→0x24, 0x25→0x25, 0x26→0x26, 0x27→0x27, 0x2a→0x2a.
REQ-018 After EXEC the state SHALL be ALU_WB; if funct is unlisted, EXEC SHALL instead pulse illegal_instr and go to FETCH.
REQ-019 ALU_WB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-020 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10 and alu_ctrl=0x20, then go to ADDI_WB.
REQ-021 ADDI_WB SHALL drive reg_write=1 and reg_dst=0, then go to FETCH.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=0x22, pc_write_cond=1 and pc_src=01, then go to FETCH.
REQ-023 JUMP SHALL drive pc_write=1 and pc_src=10, then go to FETCH.
REQ-024 Every control output not named for a state SHALL be 0 in that state, and alu_ctrl SHALL default to 0x20; no output SHALL ever be X.
REQ-025 A wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR, and increment each cycle mem_req=1 and mem_ready=0.
REQ-026 If the wait counter reaches MEM_TIMEOUT with mem_ready=0, the block SHALL pulse bus_error, drop mem_req for one cycle and enter FETCH; ir_write, pc_write and reg_write SHALL stay 0 for that request.
REQ-027 If mem_ready=1 arrives in the same cycle the counter reaches MEM_TIMEOUT, completion SHALL win and bus_error SHALL stay 0.
REQ-028 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB, ADDI_WB, BRANCH or JUMP; it SHALL wrap modulo 2^RETIRE_W and SHALL not increment on illegal or timeout exits.
REQ-029 mem_ready SHALL be ignored in every state other than FETCH, MEM_RD and MEM_WR.
REQ-030 Instruction latency, with each memory state taking 1 cycle: R-type, addi and sw 4 cycles; lw 5 cycles; beq and j 3 cycles.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in FETCH, the wait counter and retired SHALL be 0, and all control and status outputs except state SHALL be 0.
REQ-032 The first rising clk edge after rst_n deasserts SHALL start fetch handshaking, with mem_req=1.
REQ-033 Asserting rst_n mid-operation, including mid-handshake, SHALL abort immediately and drop mem_req asynchronously.

Structure
REQ-034 A shared package SHALL hold the state enum, the opcode constants (0x00, 0x23, 0x2b, 0x08, 0x04, 0x02) and the funct/ALU-code constants.
REQ-035 A sub-module alu_decoder SHALL map funct to alu_ctrl plus a valid flag, and SHALL be combinational.

Verification
REQ-036 lw (opcode 0x23) with mem_ready returned immediately -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4; retired +1.
REQ-037 R-type sub (funct 0x22) -> alu_ctrl=0x22 in EXEC; reg_write=1 with reg_dst=1 in ALU_WB; 4 cycles total.
REQ-038 opcode 0x3f -> illegal_instr pulses once in DECODE; next state FETCH; retired unchanged.
REQ-039 mem_ready held low in FETCH with MEM_TIMEOUT=3 -> bus_error pulses after 3 wait cycles; ir_write never asserts.
REQ-040 mem_ready rising exactly on the timeout cycle -> normal DECODE, bus_error=0.
REQ-041 rst_n pulled low during MEM_WR wait -> mem_req=0 with no clock edge; after release, state=0 and retired=0.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// instruction opcodes, R-type function codes and ALU operation codes.
package mc_control_unit_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EXEC    = 4'd6,
    ST_ALU_WB  = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDI_EX = 4'd9,
    ST_ADDI_WB = 4'd10,
    ST_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;
  localparam logic [5:0] ALU_XOR = 6'h26;
  localparam logic [5:0] ALU_NOR = 6'h27;
  localparam logic [5:0] ALU_SLT = 6'h2a;

  // Wide enough for the largest supported memory timeout (255).
  localparam int WAIT_W = 8;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational R-type funct to ALU operation decoder; valid is low for
// function codes the datapath does not implement.
module mc_control_unit_alu_decoder
  import mc_control_unit_pkg::*;
#(
  parameter int ALU_CTRL_W = 6
) (
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  valid
);

  always_comb begin
    alu_ctrl = ALU_CTRL_W'(ALU_ADD);
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_CTRL_W'(ALU_ADD);
      FN_SUB:  alu_ctrl = ALU_CTRL_W'(ALU_SUB);
      FN_AND:  alu_ctrl = ALU_CTRL_W'(ALU_AND);
      FN_OR:   alu_ctrl = ALU_CTRL_W'(ALU_OR);
      FN_XOR:  alu_ctrl = ALU_CTRL_W'(ALU_XOR);
      FN_NOR:  alu_ctrl = ALU_CTRL_W'(ALU_NOR);
      FN_SLT:  alu_ctrl = ALU_CTRL_W'(ALU_SLT);
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, with a memory wait timeout and retire count.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int ALU_CTRL_W  = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [3:0]            state,
  output logic                  illegal_instr,
  output logic                  bus_error,
  output logic [RETIRE_W-1:0]   retired
);

  // Memory handshake: mem_req stays high every cycle of a request until a
  // cycle with mem_ready high, which completes it; mem_ready is ignored
  // whenever mem_req is low.
  localparam logic [WAIT_W-1:0]     TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD_W   = ALU_CTRL_W'(ALU_ADD);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB_W   = ALU_CTRL_W'(ALU_SUB);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  boot_q, boot_d;
  logic                  backoff_q, backoff_d;
  logic                  is_store_q, is_store_d;
  logic [ALU_CTRL_W-1:0] dec_ctrl;
  logic                  dec_valid;
  logic                  mem_timeout;

  mc_control_unit_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .valid    (dec_valid)
  );

  assign mem_timeout = (wait_q == TIMEOUT_CNT);
  assign state       = state_q;
  assign retired     = retired_q;

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    retired_d     = retired_q;
    boot_d        = 1'b0;
    backoff_d     = 1'b0;
    is_store_d    = is_store_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_ctrl      = ALU_ADD_W;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;

    // boot_q holds every output low until the first edge after reset.
    if (boot_q) begin
      alu_ctrl = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          alu_src_b = 2'b01;
          if (!backoff_q) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = ST_DECODE;
            end else if (mem_timeout) begin
              bus_error = 1'b1;
              backoff_d = 1'b1;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        ST_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE: state_d = ST_EXEC;
            OP_LW, OP_SW: begin
              state_d    = ST_MEM_ADR;
              is_store_d = (opcode == OP_SW);
            end
            OP_ADDI:  state_d = ST_ADDI_EX;
            OP_BEQ:   state_d = ST_BRANCH;
            OP_J:     state_d = ST_JUMP;
            default: begin
              illegal_instr = 1'b1;
              state_d       = ST_FETCH;
            end
          endcase
        end
        ST_MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (is_store_q) state_d = ST_MEM_WR;
          else            state_d = ST_MEM_RD;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) begin
            state_d = ST_MEM_WB;
          end else if (mem_timeout) begin
            bus_error = 1'b1;
            backoff_d = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = ST_FETCH;
          retired_d  = retired_q + RETIRE_W'(1);
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) begin
            state_d   = ST_FETCH;
            retired_d = retired_q + RETIRE_W'(1);
          end else if (mem_timeout) begin
            bus_error = 1'b1;
            backoff_d = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = dec_ctrl;
          if (dec_valid) begin
            state_d = ST_ALU_WB;
          end else begin
            illegal_instr = 1'b1;
            state_d       = ST_FETCH;
          end
        end
        ST_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = ST_FETCH;
          retired_d = retired_q + RETIRE_W'(1);
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctrl      = ALU_SUB_W;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          state_d       = ST_FETCH;
          retired_d     = retired_q + RETIRE_W'(1);
        end
        ST_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ST_ADDI_WB;
        end
        ST_ADDI_WB: begin
          reg_write = 1'b1;
          state_d   = ST_FETCH;
          retired_d = retired_q + RETIRE_W'(1);
        end
        ST_JUMP: begin
          pc_write  = 1'b1;
          pc_src    = 2'b10;
          state_d   = ST_FETCH;
          retired_d = retired_q + RETIRE_W'(1);
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      wait_q     <= '0;
      retired_q  <= '0;
      boot_q     <= 1'b1;
      backoff_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      boot_q     <= boot_d;
      backoff_q  <= backoff_d;
      is_store_q <= is_store_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle control words from a
// per-state table, instruction vectors, and hand-written timeout/reset cases.
`timescale 1ns/1ps
module tb_mc_control_unit;

  localparam int TMO = 3;
  localparam int NV  = 14;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [5:0] alu_ctrl;
    logic       illegal;
    logic       bus_err;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  // tr lists the visited states, first state in the top nibble.
  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [5:0]  alu;
    logic        ill;
    logic        ret;
    logic [2:0]  len;
    logic [23:0] tr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        mem_req, mem_we, pc_write, pc_write_cond, i_or_d, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [5:0]  alu_ctrl;
  logic [3:0]  state;
  logic        illegal_instr, bus_error;
  logic [31:0] retired;

  logic [OBS_W-1:0] exp_q[$];
  vec_t             vecs [NV];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [31:0]      exp_ret;

  mc_control_unit #(
    .ALU_CTRL_W (6),
    .MEM_TIMEOUT(TMO),
    .RETIRE_W   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct        (funct),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_src       (pc_src),
    .alu_ctrl     (alu_ctrl),
    .state        (state),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error),
    .retired      (retired)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- expected control words ----------------
  function automatic obs_t spec_word(input logic [3:0] st);
    obs_t o;
    o          = '0;
    o.state    = st;
    o.alu_ctrl = 6'h20;
    case (st)
      4'd0:  begin o.mem_req = 1'b1; o.alu_src_b = 2'b01; end
      4'd1:  o.alu_src_b = 2'b11;
      4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd3:  begin o.mem_req = 1'b1; o.i_or_d = 1'b1; end
      4'd4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      4'd5:  begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.i_or_d = 1'b1; end
      4'd6:  o.alu_src_a = 1'b1;
      4'd7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      4'd8:  begin
        o.alu_src_a = 1'b1; o.alu_ctrl = 6'h22; o.pc_write_cond = 1'b1; o.pc_src = 2'b01;
      end
      4'd9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd10: o.reg_write = 1'b1;
      4'd11: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t fetch_accept();
    obs_t o;
    o          = spec_word(4'd0);
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.state         = state;
    o.mem_req       = mem_req;
    o.mem_we        = mem_we;
    o.i_or_d        = i_or_d;
    o.ir_write      = ir_write;
    o.pc_write      = pc_write;
    o.pc_write_cond = pc_write_cond;
    o.reg_write     = reg_write;
    o.reg_dst       = reg_dst;
    o.mem_to_reg    = mem_to_reg;
    o.alu_src_a     = alu_src_a;
    o.alu_src_b     = alu_src_b;
    o.pc_src        = pc_src;
    o.alu_ctrl      = alu_ctrl;
    o.illegal       = illegal_instr;
    o.bus_err       = bus_error;
    return o;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  // ---------------- scoreboard ----------------
  task automatic push(input obs_t o);
    logic [OBS_W-1:0] w;
    w = o;
    exp_q.push_back(w);
  endtask

  task automatic check_obs(input string tag);
    logic [OBS_W-1:0] got, exp;
    got = cur_obs();
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %h but expected queue is empty", tag, got);
    end else begin
      exp = exp_q.pop_front();
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                    tag, got, got[OBS_W-1 -: 4], exp, exp[OBS_W-1 -: 4]);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input string tag);
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    @(negedge clk);
    check_obs(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] st;
    obs_t       e;
    logic [5:0] op, fn;
    logic       rdy;
    for (int k = 0; k < int'(v.len); k++) begin
      st = v.tr[23-4*k -: 4];
      e  = (st == 4'd0) ? fetch_accept() : spec_word(st);
      if (st == 4'd6) e.alu_ctrl = v.alu;
      if (v.ill && k == int'(v.len) - 1) e.illegal = 1'b1;
      push(e);
    end
    for (int k = 0; k < int'(v.len); k++) begin
      st  = v.tr[23-4*k -: 4];
      op  = (st == 4'd1 || st == 4'd6) ? v.op : rnd6();
      fn  = (st == 4'd6) ? v.fn : rnd6();
      rdy = (st == 4'd0 || st == 4'd3 || st == 4'd5) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(op, fn, rdy, $sformatf("%s_c%0d", tag, k));
    end
    exp_ret = exp_ret + 32'(v.ret);
    check_val($sformatf("%s_retired", tag), retired, exp_ret);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    obs_t e;
    rst_n     = 1'b0;
    opcode    = '0;
    funct     = '0;
    mem_ready = 1'b0;
    exp_ret   = '0;

    vecs[0]  = '{op:6'h23, fn:6'h00, alu:6'h20, ill:1'b0, ret:1'b1, len:3'd5, tr:24'h012340};
    vecs[1]  = '{op:6'h2b, fn:6'h00, alu:6'h20, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h012500};
    vecs[2]  = '{op:6'h00, fn:6'h20, alu:6'h20, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[3]  = '{op:6'h00, fn:6'h22, alu:6'h22, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[4]  = '{op:6'h00, fn:6'h24, alu:6'h24, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[5]  = '{op:6'h00, fn:6'h25, alu:6'h25, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[6]  = '{op:6'h00, fn:6'h26, alu:6'h26, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[7]  = '{op:6'h00, fn:6'h27, alu:6'h27, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[8]  = '{op:6'h00, fn:6'h2a, alu:6'h2a, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h016700};
    vecs[9]  = '{op:6'h08, fn:6'h00, alu:6'h20, ill:1'b0, ret:1'b1, len:3'd4, tr:24'h019A00};
    vecs[10] = '{op:6'h04, fn:6'h00, alu:6'h20, ill:1'b0, ret:1'b1, len:3'd3, tr:24'h018000};
    vecs[11] = '{op:6'h02, fn:6'h00, alu:6'h20, ill:1'b0, ret:1'b1, len:3'd3, tr:24'h01B000};
    vecs[12] = '{op:6'h3f, fn:6'h00, alu:6'h20, ill:1'b1, ret:1'b0, len:3'd2, tr:24'h010000};
    vecs[13] = '{op:6'h00, fn:6'h21, alu:6'h20, ill:1'b1, ret:1'b0, len:3'd3, tr:24'h016000};

    // Reset: all outputs low even with mem_ready driven high.
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    push('0);
    @(negedge clk);
    check_obs("reset_outputs");
    check_val("reset_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push('0);
    @(negedge clk);
    check_obs("before_first_edge");
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < NV; i++) begin
      int j;
      j = int'($urandom_range(0, NV - 1));
      run_vec(vecs[j], $sformatf("rvec%0d", j));
    end

    // Fetch timeout: bus_error on the cycle the wait count reaches TMO,
    // then one cycle with mem_req low where mem_ready must be ignored.
    for (int k = 0; k < TMO; k++) push(spec_word(4'd0));
    e = spec_word(4'd0); e.bus_err = 1'b1; push(e);
    e = spec_word(4'd0); e.mem_req = 1'b0; push(e);
    for (int k = 0; k <= TMO; k++) cyc(rnd6(), rnd6(), 1'b0, $sformatf("fetch_wait%0d", k));
    cyc(rnd6(), rnd6(), 1'b1, "fetch_backoff");
    check_val("fetch_timeout_retired", retired, exp_ret);
    run_vec(vecs[10], "after_fetch_timeout");

    // mem_ready arriving on the timeout cycle completes normally.
    for (int k = 0; k < TMO; k++) push(spec_word(4'd0));
    for (int k = 0; k < TMO; k++) cyc(rnd6(), rnd6(), 1'b0, $sformatf("fetch_slow%0d", k));
    run_vec(vecs[11], "ready_at_timeout");

    // Load whose read never completes.
    push(fetch_accept());
    push(spec_word(4'd1));
    push(spec_word(4'd2));
    for (int k = 0; k < TMO; k++) push(spec_word(4'd3));
    e = spec_word(4'd3); e.bus_err = 1'b1; push(e);
    e = spec_word(4'd0); e.mem_req = 1'b0; push(e);
    cyc(rnd6(), rnd6(), 1'b1, "lw_fetch");
    cyc(6'h23, rnd6(), 1'($urandom_range(0, 1)), "lw_decode");
    cyc(rnd6(), rnd6(), 1'($urandom_range(0, 1)), "lw_adr");
    for (int k = 0; k <= TMO; k++) cyc(rnd6(), rnd6(), 1'b0, $sformatf("lw_rd_wait%0d", k));
    cyc(rnd6(), rnd6(), 1'b1, "lw_backoff");
    check_val("rd_timeout_retired", retired, exp_ret);

    // Reset asserted between clock edges while a store waits.
    push(fetch_accept());
    push(spec_word(4'd1));
    push(spec_word(4'd2));
    push(spec_word(4'd5));
    cyc(rnd6(), rnd6(), 1'b1, "sw_fetch");
    cyc(6'h2b, rnd6(), 1'($urandom_range(0, 1)), "sw_decode");
    cyc(rnd6(), rnd6(), 1'($urandom_range(0, 1)), "sw_adr");
    cyc(rnd6(), rnd6(), 1'b0, "sw_wr_wait");
    #2;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    push('0);
    check_obs("reset_mid_store");
    check_val("reset_mid_store_retired", retired, 32'd0);
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push('0);
    @(negedge clk);
    check_obs("after_release");
    @(posedge clk);
    #1;
    run_vec(vecs[3], "after_reset");
    run_vec(vecs[0], "after_reset_lw");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
